// File: rtl/pattern_ctrl_if.sv
// Pattern-select control bundle: button/auto/vsync toward the sequencer,
// mode select and status back toward the VGA top level.
interface pattern_ctrl_if;
    logic       BTN;
    logic       AUTO;
    logic       VGA_VS;
    logic [2:0] MODE;
    logic       MODE_CHG;
    logic       PEND;

    modport master (
        output BTN,
        output AUTO,
        output VGA_VS,
        input  MODE,
        input  MODE_CHG,
        input  PEND
    );

    modport slave (
        input  BTN,
        input  AUTO,
        input  VGA_VS,
        output MODE,
        output MODE_CHG,
        output PEND
    );
endinterface

// File: rtl/pattern_ctrl.sv
// Test-pattern sequencer: debounced button or frame timer requests a mode
// advance, which is applied only at the leading edge of vertical sync.
module pattern_ctrl #(
    parameter int NMODE       = 8,
    parameter int DEB_CYC     = 250000,
    parameter int AUTO_FRAMES = 120,
    parameter bit VS_POL      = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    pattern_ctrl_if.slave   bus
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int FW = $clog2(AUTO_FRAMES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(AUTO_FRAMES - 1);
    localparam logic [2:0]    MODE_LAST = 3'(NMODE - 1);

    typedef enum logic {IDLE, PEND_S} state_t;

    logic          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic          btn_stable_q, btn_stable_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic          mode_chg_q, mode_chg_d;

    logic press, frame_start, auto_req, advance;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_s1_q     <= 1'b0;
            btn_s2_q     <= 1'b0;
            btn_stable_q <= 1'b0;
            deb_cnt_q    <= '0;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_s3_q      <= 1'b0;
            frm_cnt_q    <= '0;
            state_q      <= IDLE;
            mode_q       <= 3'd0;
            mode_chg_q   <= 1'b0;
        end else begin
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            btn_stable_q <= btn_stable_d;
            deb_cnt_q    <= deb_cnt_d;
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            vs_s3_q      <= vs_s3_d;
            frm_cnt_q    <= frm_cnt_d;
            state_q      <= state_d;
            mode_q       <= mode_d;
            mode_chg_q   <= mode_chg_d;
        end
    end

    // Button path: the counter runs only while the synchronized level
    // disagrees with the accepted state; any agreement restarts it.
    always_comb begin
        btn_s1_d     = bus.BTN;
        btn_s2_d     = btn_s1_q;
        btn_stable_d = btn_stable_q;
        deb_cnt_d    = '0;
        press        = 1'b0;
        if (btn_s2_q != btn_stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_stable_d = btn_s2_q;
                press        = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Vsync edge detect and auto-cycle frame counter.
    always_comb begin
        vs_s1_d     = bus.VGA_VS;
        vs_s2_d     = vs_s1_q;
        vs_s3_d     = vs_s2_q;
        frame_start = (vs_s2_q == VS_POL) && (vs_s3_q != VS_POL);
        frm_cnt_d   = frm_cnt_q;
        auto_req    = 1'b0;
        if (!bus.AUTO) begin
            frm_cnt_d = '0;
        end else if (frame_start) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d = '0;
                auto_req  = 1'b1;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    // auto_req is always frame-aligned, so from IDLE it advances directly.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (auto_req) begin
                    advance = 1'b1;
                end else if (press) begin
                    state_d = PEND_S;
                end
            end
            PEND_S: begin
                if (frame_start) begin
                    advance = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mode_d     = mode_q;
        if (advance) begin
            mode_d = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
        end
        mode_chg_d = advance;
    end

    assign bus.MODE     = mode_q;
    assign bus.MODE_CHG = mode_chg_q;
    assign bus.PEND     = (state_q == PEND_S);
endmodule

// File: tb/tb_pattern_ctrl.sv
// Scoreboard bench for pattern_ctrl: a frame-level model queues expected
// modes, and a negedge monitor checks each MODE_CHG against the queue.
module tb_pattern_ctrl;
    localparam int NMODE = 5;
    localparam int DEB   = 4;
    localparam int AF    = 3;
    localparam bit VSP   = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pattern_ctrl_if bus ();

    pattern_ctrl #(
        .NMODE(NMODE), .DEB_CYC(DEB), .AUTO_FRAMES(AF), .VS_POL(VSP)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int mon_e;
    int m_mode = 0;
    int m_pend = 0;
    int m_cnt  = 0;
    bit m_auto = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every MODE_CHG must match the next queued expected mode.
    always @(negedge clk) begin
        if (!rst && bus.MODE_CHG) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mode_chg_unexpected: MODE=%0d with no advance expected", bus.MODE);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(bus.MODE) != mon_e) begin
                    n_fail++;
                    $display("FAIL mode_after_chg: got %0d, expected %0d", bus.MODE, mon_e);
                end else begin
                    $display("[TB] advance MODE=%0d ok", bus.MODE);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model, one call per request / per frame.
    task automatic model_press();
        m_pend = 1;
    endtask

    task automatic model_frame();
        bit adv;
        adv    = (m_pend != 0);
        m_pend = 0;
        if (m_auto) begin
            m_cnt++;
            if (m_cnt == AF) begin
                m_cnt = 0;
                adv   = 1'b1;
            end
        end else begin
            m_cnt = 0;
        end
        if (adv) begin
            m_mode = (m_mode + 1) % NMODE;
            exp_q.push_back(m_mode);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_auto(bit b);
        bus.AUTO = b;
        m_auto   = b;
        if (!b) m_cnt = 0;
    endtask

    task automatic do_press(int nb);
        for (int r = 0; r < nb; r++) begin
            bus.BTN = (r % 2 == 0);
            tick($urandom_range(2, 1));
        end
        bus.BTN = 1'b0;
        tick(2);
        bus.BTN = 1'b1;
        tick(10);
        bus.BTN = 1'b0;
        tick(10);
        model_press();
    endtask

    task automatic do_frame();
        model_frame();
        bus.VGA_VS = 1'b0;
        tick(4);
        bus.VGA_VS = 1'b1;
        tick(6);
        chk("mode_after_frame", int'(bus.MODE), m_mode);
        chk("pend_after_frame", int'(bus.PEND), 0);
        $display("[TB] frame done MODE=%0d auto=%0d", bus.MODE, m_auto);
    endtask

    initial begin
        int n;
        bus.BTN    = 1'b0;
        bus.AUTO   = 1'b0;
        bus.VGA_VS = 1'b1;
        #1 rst = 1'b1;
        tick(2);
        chk("reset_mode", int'(bus.MODE), 0);
        chk("reset_pend", int'(bus.PEND), 0);
        chk("reset_mode_chg", int'(bus.MODE_CHG), 0);
        rst = 1'b0;
        tick(4);

        // Bring MODE to 2, then check frame-alignment latency.
        repeat (2) begin
            do_press(0);
            do_frame();
        end
        do_press(0);
        chk("pend_set", int'(bus.PEND), 1);
        model_frame();
        bus.VGA_VS = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < 3) begin
                chk("mode_hold_before_edge3", int'(bus.MODE), 2);
                chk("pend_hold_before_edge3", int'(bus.PEND), 1);
            end else begin
                chk("mode_at_edge3", int'(bus.MODE), 3);
                chk("mode_chg_at_edge3", int'(bus.MODE_CHG), 1);
                chk("pend_drop_at_edge3", int'(bus.PEND), 0);
            end
        end
        @(negedge clk);
        chk("mode_chg_one_cycle", int'(bus.MODE_CHG), 0);
        bus.VGA_VS = 1'b1;
        tick(6);
        $display("[TB] latency test done MODE=%0d", bus.MODE);

        // Debounce: bounce every 2 cycles, then hold.
        for (int i = 0; i < 20; i++) begin
            bus.BTN = ((i / 2) % 2 == 0);
            tick();
        end
        chk("no_pend_during_bounce", int'(bus.PEND), 0);
        bus.BTN = 1'b1;
        n = 0;
        while (!bus.PEND && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n < 5 || n > 6) begin
            n_fail++;
            $display("FAIL debounce_latency: PEND rose after %0d cycles, required 5..6", n);
        end
        $display("[TB] debounce PEND after %0d cycles", n);
        model_press();
        tick(4);
        do_frame();
        bus.BTN = 1'b0;
        tick(12);
        chk("release_no_request", int'(bus.PEND), 0);

        // Merging and wrap: three presses, one frame, 4 -> 0.
        repeat (3) do_press($urandom_range(6));
        do_frame();
        do_frame();
        chk("merge_wrap_mode", int'(bus.MODE), 0);

        // Reset in the middle of a pending request with MODE=3.
        repeat (3) begin
            do_press(0);
            do_frame();
        end
        do_press(0);
        chk("pend_before_reset", int'(bus.PEND), 1);
        chk("mode_before_reset", int'(bus.MODE), 3);
        rst = 1'b1;
        #1;
        chk("async_reset_mode", int'(bus.MODE), 0);
        chk("async_reset_pend", int'(bus.PEND), 0);
        chk("async_reset_mode_chg", int'(bus.MODE_CHG), 0);
        exp_q.delete();
        m_mode = 0;
        m_pend = 0;
        m_cnt  = 0;
        tick(2);
        rst = 1'b0;
        tick(3);
        do_frame();

        // Auto-cycle: 9 frames, then restart of the frame count.
        set_auto(1'b1);
        tick(2);
        repeat (9) do_frame();
        repeat (2) do_frame();
        set_auto(1'b0);
        tick(2);
        set_auto(1'b1);
        tick(2);
        repeat (3) do_frame();

        // Coincidence: press pulse, frame_start and auto_req on one edge while PEND.
        set_auto(1'b0);
        tick(2);
        set_auto(1'b1);
        tick(2);
        repeat (2) do_frame();
        do_press(0);
        model_frame();
        bus.BTN = 1'b1;
        tick(3);
        bus.VGA_VS = 1'b0;
        tick(4);
        bus.VGA_VS = 1'b1;
        tick(6);
        bus.BTN = 1'b0;
        set_auto(1'b0);
        tick(12);
        chk("coincide_mode", int'(bus.MODE), m_mode);
        chk("coincide_idle", int'(bus.PEND), 0);
        do_frame();

        // Randomized mix of presses, auto enable and frames.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3) == 0) begin
                set_auto(1'($urandom_range(1)));
                tick(2);
            end
            repeat ($urandom_range(2)) do_press($urandom_range(6));
            do_frame();
        end

        tick(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
